// File: rtl/mdu_pkg.sv
// Shared constants for the HI/LO multiply/divide unit: op codes, FSM states,
// datapath width and iteration count.
package mdu_pkg;

  localparam int DATA_W = 32;
  localparam int ITER   = 32;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/mdu_signfix.sv
// Combinational conditional two's-complement negate; gives |x| when i_neg is
// the sign of x, and applies the result sign at the end of an operation.
module mdu_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/mdu_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// Define MDU_ZERO_SHORTCUT_EN to finish operations with a zero operand in one cycle.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int DATA_W = mdu_pkg::DATA_W,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MDU_start,
  input  logic [1:0]        MDU_op,
  input  logic [DATA_W-1:0] MDU_src_a,
  input  logic [DATA_W-1:0] MDU_src_b,
  input  logic              MDU_mthi,
  input  logic              MDU_mtlo,
  output logic              MDU_busy,
  output logic              MDU_done,
  output logic [DATA_W-1:0] MDU_hi,
  output logic [DATA_W-1:0] MDU_lo
);

  localparam int AW = 2 * DATA_W;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_is_div;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_div0;
  logic [DATA_W-1:0] r_opnd;
  logic [AW-1:0]     r_acc;
  logic [DATA_W-1:0] r_hi, r_lo;
  logic              r_done;

  // Operand decode and magnitudes
  logic              w_is_div, w_signed, w_a_neg, w_b_neg, w_b_zero, w_zero;
  logic [DATA_W-1:0] w_abs_a, w_abs_b;

  assign w_is_div = (MDU_op == MDU_DIV) || (MDU_op == MDU_DIVU);
  assign w_signed = (MDU_op == MDU_MULT) || (MDU_op == MDU_DIV);
  assign w_a_neg  = w_signed & MDU_src_a[DATA_W-1];
  assign w_b_neg  = w_signed & MDU_src_b[DATA_W-1];
  assign w_b_zero = (MDU_src_b == '0);

`ifdef MDU_ZERO_SHORTCUT_EN
  assign w_zero = (MDU_src_a == '0) || w_b_zero;
`else
  assign w_zero = 1'b0;
`endif

  mdu_signfix #(.W(DATA_W)) u_abs_a (.i_val(MDU_src_a), .i_neg(w_a_neg), .o_val(w_abs_a));
  mdu_signfix #(.W(DATA_W)) u_abs_b (.i_val(MDU_src_b), .i_neg(w_b_neg), .o_val(w_abs_b));

  // One shift-add multiply step: r_acc = {partial product, remaining multiplier bits}
  logic [DATA_W:0] w_mul_sum;
  logic [AW-1:0]   w_mul_nxt;

  assign w_mul_sum = {1'b0, r_acc[AW-1:DATA_W]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_nxt = {w_mul_sum, r_acc[DATA_W-1:1]};

  // One restoring divide step: r_acc = {remainder, dividend/quotient bits}
  logic [DATA_W:0] w_div_part, w_div_rem;
  logic            w_div_ge;
  logic [AW-1:0]   w_div_nxt;

  assign w_div_part = r_acc[AW-1:DATA_W-1];
  assign w_div_ge   = (w_div_part >= {1'b0, r_opnd});
  assign w_div_rem  = w_div_ge ? (w_div_part - {1'b0, r_opnd}) : w_div_part;
  assign w_div_nxt  = {w_div_rem[DATA_W-1:0], r_acc[DATA_W-2:0], w_div_ge};

  // Sign correction applied at FIX
  logic [AW-1:0]     w_prod;
  logic [DATA_W-1:0] w_quo, w_rem, w_fix_hi, w_fix_lo;

  mdu_signfix #(.W(AW))     u_fix_prod (.i_val(r_acc),                 .i_neg(r_neg_q), .o_val(w_prod));
  mdu_signfix #(.W(DATA_W)) u_fix_quo  (.i_val(r_acc[DATA_W-1:0]),     .i_neg(r_neg_q), .o_val(w_quo));
  mdu_signfix #(.W(DATA_W)) u_fix_rem  (.i_val(r_acc[AW-1:DATA_W]),    .i_neg(r_neg_r), .o_val(w_rem));

  assign w_fix_hi = r_is_div ? w_rem : w_prod[AW-1:DATA_W];
  assign w_fix_lo = r_is_div ? (r_div0 ? '1 : w_quo) : w_prod[DATA_W-1:0];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (MDU_start) w_state_nxt = w_zero ? S_FIX : S_CALC;
      S_CALC:  if (r_cnt == CNT_W'(ITER - 1)) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: datapath registers are reset too, so an aborted operation leaves no stale partial state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (MDU_start) begin
            r_cnt    <= '0;
            r_is_div <= w_is_div;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_div0   <= w_is_div & w_b_zero;
            r_opnd   <= w_is_div ? w_abs_b : w_abs_a;
            // A zero-operand shortcut preloads the final magnitudes and goes straight to FIX
            if (w_zero)
              r_acc <= (w_is_div && w_b_zero) ? {w_abs_a, {DATA_W{1'b0}}} : '0;
            else
              r_acc <= {{DATA_W{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
          end else begin
            if (MDU_mthi) r_hi <= MDU_src_a;
            if (MDU_mtlo) r_lo <= MDU_src_a;
          end
        end
        S_CALC: begin
          r_acc <= r_is_div ? w_div_nxt : w_mul_nxt;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        S_FIX: begin
          r_hi   <= w_fix_hi;
          r_lo   <= w_fix_lo;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign MDU_busy = (r_state != S_IDLE);
  assign MDU_done = r_done;
  assign MDU_hi   = r_hi;
  assign MDU_lo   = r_lo;

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: latency-level reference model compared every
// cycle, plus directed vectors with hand-computed HI/LO values.
module tb_mdu_hilo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        MDU_start = 1'b0;
  logic [1:0]  MDU_op = 2'b00;
  logic [31:0] MDU_src_a = '0;
  logic [31:0] MDU_src_b = '0;
  logic        MDU_mthi = 1'b0;
  logic        MDU_mtlo = 1'b0;
  logic        MDU_busy, MDU_done;
  logic [31:0] MDU_hi, MDU_lo;

  always #5 clk = ~clk;

  mdu_hilo dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .MDU_start (MDU_start),
    .MDU_op    (MDU_op),
    .MDU_src_a (MDU_src_a),
    .MDU_src_b (MDU_src_b),
    .MDU_mthi  (MDU_mthi),
    .MDU_mtlo  (MDU_mtlo),
    .MDU_busy  (MDU_busy),
    .MDU_done  (MDU_done),
    .MDU_hi    (MDU_hi),
    .MDU_lo    (MDU_lo)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference arithmetic straight from the instruction definitions
  function automatic logic [63:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] qv, rv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: return 64'(sa * sb);
      2'b01: return {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb; r = sa % sb;
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = longint'({32'b0, a}) / longint'({32'b0, b});
        r = longint'({32'b0, a}) % longint'({32'b0, b});
      end
    endcase
    qv = 64'(q);
    rv = 64'(r);
    return {rv[31:0], qv[31:0]};
  endfunction

  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef MDU_ZERO_SHORTCUT_EN
    if (a == 0 || b == 0) return 1;
`endif
    return 33;
  endfunction

  // Model: a pending result that lands after a fixed number of edges
  logic [31:0] m_hi, m_lo, m_pend_hi, m_pend_lo;
  logic        m_done;
  int          m_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi <= '0; m_lo <= '0; m_done <= 1'b0; m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_left != 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hi <= m_pend_hi; m_lo <= m_pend_lo; m_done <= 1'b1;
        end
      end else if (MDU_start) begin
        {m_pend_hi, m_pend_lo} <= ref_op(MDU_op, MDU_src_a, MDU_src_b);
        m_left <= ref_lat(MDU_src_a, MDU_src_b);
      end else begin
        if (MDU_mthi) m_hi <= MDU_src_a;
        if (MDU_mtlo) m_lo <= MDU_src_a;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("cyc busy", 64'(MDU_busy), 64'(m_left != 0));
      check("cyc done", 64'(MDU_done), 64'(m_done));
      check("cyc hi",   64'(MDU_hi),   64'(m_hi));
      check("cyc lo",   64'(MDU_lo),   64'(m_lo));
    end
  end

  // All tasks start and end on a falling edge
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    MDU_op = op; MDU_src_a = a; MDU_src_b = b; MDU_start = 1'b1;
    @(negedge clk);
    MDU_start = 1'b0;
    MDU_src_a = $urandom;
    MDU_src_b = $urandom;
  endtask

  task automatic wait_done(input string name, input int exp_lat,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n = 0;
    int nb = 0;
    while (!MDU_done && n < 60) begin
      if (MDU_busy) nb++;
      @(negedge clk);
      n++;
    end
    check({name, " latency"}, 64'(n), 64'(exp_lat));
    check({name, " busy cycles"}, 64'(nb), 64'(exp_lat));
    check({name, " hi"}, 64'(MDU_hi), 64'(exp_hi));
    check({name, " lo"}, 64'(MDU_lo), 64'(exp_lo));
  endtask

  task automatic mt(input logic hi, input logic lo, input logic [31:0] val);
    MDU_mthi = hi; MDU_mtlo = lo; MDU_src_a = val;
    @(negedge clk);
    MDU_mthi = 1'b0; MDU_mtlo = 1'b0;
  endtask

  int zl;

  initial begin
    zl = ref_lat(32'd5, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("reset hi",   64'(MDU_hi),   64'h0);
    check("reset lo",   64'(MDU_lo),   64'h0);
    check("reset busy", 64'(MDU_busy), 64'h0);
    check("reset done", 64'(MDU_done), 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back operations: each new start lands in the done cycle
    issue(2'b00, 32'd7, 32'hFFFF_FFFD);
    wait_done("mult 7*-3", 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu max", 33, 32'hFFFF_FFFE, 32'h0000_0001);
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("mult -1*-1", 33, 32'h0, 32'h1);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done("div -7/2", 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(2'b11, 32'd7, 32'd2);
    wait_done("divu 7/2", 33, 32'd1, 32'd3);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div ovf", 33, 32'h0, 32'h8000_0000);
    issue(2'b11, 32'd5, 32'd0);
    wait_done("divu 5/0", zl, 32'd5, 32'hFFFF_FFFF);
    issue(2'b10, 32'hFFFF_FFF7, 32'd0);
    wait_done("div -9/0", zl, 32'hFFFF_FFF7, 32'hFFFF_FFFF);
    issue(2'b00, 32'h1234, 32'd0);
    wait_done("mult x0", zl, 32'h0, 32'h0);
    issue(2'b10, 32'd0, 32'd5);
    wait_done("div 0/5", zl, 32'h0, 32'h0);

    // Start and MTHI while busy are ignored
    issue(2'b00, 32'd3, 32'd5);
    repeat (5) @(negedge clk);
    MDU_op = 2'b01; MDU_src_a = 32'd9; MDU_src_b = 32'd9;
    MDU_start = 1'b1; MDU_mthi = 1'b1;
    @(negedge clk);
    MDU_start = 1'b0; MDU_mthi = 1'b0;
    wait_done("busy ignore", 27, 32'h0, 32'd15);
    @(negedge clk);
    check("busy ignore no restart", 64'(MDU_busy), 64'h0);

    mt(1'b1, 1'b0, 32'h1234);
    check("mthi hi", 64'(MDU_hi), 64'h1234);
    check("mthi lo", 64'(MDU_lo), 64'd15);
    mt(1'b0, 1'b1, 32'hABCD);
    check("mtlo hi", 64'(MDU_hi), 64'h1234);
    check("mtlo lo", 64'(MDU_lo), 64'hABCD);
    mt(1'b1, 1'b1, 32'h55);
    check("mt both hi", 64'(MDU_hi), 64'h55);
    check("mt both lo", 64'(MDU_lo), 64'h55);

    // Start wins over a same-cycle MTHI
    MDU_mthi = 1'b1;
    issue(2'b00, 32'd2, 32'd3);
    MDU_mthi = 1'b0;
    check("start beats mthi", 64'(MDU_hi), 64'h55);
    wait_done("mult 2*3", 33, 32'h0, 32'd6);

    // Asynchronous reset in the middle of a divide
    mt(1'b1, 1'b0, 32'hDEAD);
    issue(2'b10, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort hi",   64'(MDU_hi),   64'h0);
    check("abort lo",   64'(MDU_lo),   64'h0);
    check("abort busy", 64'(MDU_busy), 64'h0);
    check("abort done", 64'(MDU_done), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(2'b00, 32'hFFFF_FFFC, 32'd6);
    wait_done("mult after reset", 33, 32'hFFFF_FFFF, 32'hFFFF_FFE8);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
